// File: rtl/led_status_scheduler.sv
// Per-unit RGB status sequencer: routes event pulses to the active fault zone and runs one FSM per LED.
// Latency: event or unit_active edge updates state on the sampling edge; registered pins follow one edge later.
// No backpressure: pulses not accepted by the target state are dropped. Optional blinking via LED_BLINK_EN.
module led_status_scheduler #(
    parameter int unsigned BLINK_HALF = 32'd1562500,
    parameter int unsigned HOLD_TICKS = 32'd3125000
) (
    input  logic       clk_3125KHz,
    input  logic       reset,
    input  logic [2:0] unit_active,
    input  logic       fault_detect,
    input  logic       block_picked,
    input  logic       object_drop,
    input  logic       run_complete,
    output logic [2:0] led_r,
    output logic [2:0] led_g,
    output logic [2:0] led_b,
    output logic       run_done
);

    typedef enum logic [2:0] {
        ST_OFF, ST_ZONE, ST_FAULT, ST_CARRY, ST_DROP, ST_CLEARED
    } chan_state_t;

    chan_state_t state      [3];
    chan_state_t state_nxt  [3];
    logic [31:0] hold_cnt   [3];
    logic [31:0] hold_nxt   [3];
    logic [2:0]  active_prev;
    logic [2:0]  target;
    logic [2:0]  r_nxt, g_nxt, b_nxt;
    logic        freeze;
    logic        ev_fault, ev_pick, ev_drop;
    logic        green_on;

`ifdef LED_BLINK_EN
    logic [31:0] blink_cnt;
    logic        blink_phase;

    always_ff @(posedge clk_3125KHz) begin
        if (reset) begin
            blink_cnt   <= 32'd0;
            blink_phase <= 1'b1;
        end else if (blink_cnt == BLINK_HALF - 32'd1) begin
            blink_cnt   <= 32'd0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 32'd1;
        end
    end

    assign green_on = blink_phase;
`else
    // Blink period is irrelevant when green is steady; parameter kept for a uniform interface.
    logic blink_half_unused;
    assign blink_half_unused = ^BLINK_HALF;
    assign green_on          = 1'b1;
`endif

    always_comb begin
        target = 3'b000;
        if (unit_active[0])      target = 3'b001;
        else if (unit_active[1]) target = 3'b010;
        else if (unit_active[2]) target = 3'b100;
    end

    // run_complete wins over any same-cycle event and freezes every channel from then on.
    assign freeze   = run_done | run_complete;
    assign ev_drop  = object_drop & ~freeze;
    assign ev_pick  = block_picked & ~object_drop & ~freeze;
    assign ev_fault = fault_detect & ~object_drop & ~block_picked & ~freeze;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            state_nxt[i] = state[i];
            hold_nxt[i]  = hold_cnt[i];
            if (!freeze) begin
                case (state[i])
                    ST_OFF:   if (unit_active[i] && !active_prev[i]) state_nxt[i] = ST_ZONE;
                    ST_ZONE: begin
                        if (target[i] && ev_fault) state_nxt[i] = ST_FAULT;
                        else if (!unit_active[i])  state_nxt[i] = ST_OFF;
                    end
                    ST_FAULT: if (target[i] && ev_pick) state_nxt[i] = ST_CARRY;
                    ST_CARRY: begin
                        if (target[i] && ev_drop) begin
                            state_nxt[i] = ST_DROP;
                            hold_nxt[i]  = 32'd0;
                        end
                    end
                    ST_DROP: begin
                        if (hold_cnt[i] == HOLD_TICKS - 32'd1) state_nxt[i] = ST_CLEARED;
                        else                                   hold_nxt[i]  = hold_cnt[i] + 32'd1;
                    end
                    ST_CLEARED: state_nxt[i] = ST_CLEARED;
                    default:    state_nxt[i] = ST_OFF;
                endcase
            end
        end
    end

    always_comb begin
        r_nxt = 3'b000;
        g_nxt = 3'b000;
        b_nxt = 3'b000;
        if (run_done) begin
            g_nxt = {3{green_on}};
        end else begin
            for (int i = 0; i < 3; i++) begin
                case (state[i])
                    ST_ZONE:    r_nxt[i] = 1'b1;
                    ST_FAULT:   b_nxt[i] = 1'b1;
                    ST_CARRY: begin
                        r_nxt[i] = 1'b1;
                        b_nxt[i] = 1'b1;
                    end
                    ST_DROP:    g_nxt[i] = green_on;
                    ST_CLEARED: g_nxt[i] = 1'b1;
                    default:    ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_3125KHz) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                state[i]    <= ST_OFF;
                hold_cnt[i] <= 32'd0;
            end
            active_prev <= 3'b000;
            run_done    <= 1'b0;
            led_r       <= 3'b000;
            led_g       <= 3'b000;
            led_b       <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                state[i]    <= state_nxt[i];
                hold_cnt[i] <= hold_nxt[i];
            end
            active_prev <= unit_active;
            if (run_complete) run_done <= 1'b1;
            led_r <= r_nxt;
            led_g <= g_nxt;
            led_b <= b_nxt;
        end
    end

endmodule
